// File: rtl/mem_arb.sv
// mem_arb: shares one downstream memory port between the fetch unit (IFU) and
// the load/store unit (LSU). Only one transaction is in flight at a time.
// When both units request at once, the grant alternates between them.
module mem_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // fetch port
  input  logic                  i_ifu_req_valid,
  output logic                  o_ifu_req_ready,
  input  logic [ADDR_W-1:0]     i_ifu_addr,
  output logic                  o_ifu_rsp_valid,
  output logic [DATA_W-1:0]     o_ifu_rdata,
  // load/store port
  input  logic                  i_lsu_req_valid,
  output logic                  o_lsu_req_ready,
  input  logic [ADDR_W-1:0]     i_lsu_addr,
  input  logic                  i_lsu_wen,
  input  logic [DATA_W-1:0]     i_lsu_wdata,
  input  logic [DATA_W/8-1:0]   i_lsu_wmask,
  output logic                  o_lsu_rsp_valid,
  output logic [DATA_W-1:0]     o_lsu_rdata,
  // downstream memory port
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_wen,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wmask,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t              state_q, state_d;
  logic                owner_q;
  logic                last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;

  logic grant_ifu, grant_lsu;
  logic req_act, rsp_fire;

  // next state and round-robin grant; grants only happen in IDLE
  always_comb begin
    state_d   = state_q;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ifu_req_valid && (!i_lsu_req_valid || last_q == OWN_LSU))
          grant_ifu = 1'b1;
        else if (i_lsu_req_valid)
          grant_lsu = 1'b1;
        if (grant_ifu || grant_lsu) state_d = REQ;
      end
      REQ:     if (i_mem_req_ready) state_d = RSP;
      RSP:     if (i_mem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, ownership and latched payload; fetches carry an all-zero write payload
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_ifu) begin
        owner_q <= OWN_IFU;
        last_q  <= OWN_IFU;
        addr_q  <= i_ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end else if (grant_lsu) begin
        owner_q <= OWN_LSU;
        last_q  <= OWN_LSU;
        addr_q  <= i_lsu_addr;
        wen_q   <= i_lsu_wen;
        wdata_q <= i_lsu_wdata;
        wmask_q <= i_lsu_wmask;
      end
    end
  end

  // outputs are forced quiet while reset is held, even before the state register clears
  always_comb begin
    req_act  = (state_q == REQ) && !i_rst;
    rsp_fire = (state_q == RSP) && i_mem_rsp_valid && !i_rst;

    o_ifu_req_ready = grant_ifu && !i_rst;
    o_lsu_req_ready = grant_lsu && !i_rst;

    o_mem_req_valid = req_act;
    o_mem_addr      = req_act ? addr_q  : '0;
    o_mem_wen       = req_act ? wen_q   : 1'b0;
    o_mem_wdata     = req_act ? wdata_q : '0;
    o_mem_wmask     = req_act ? wmask_q : '0;

    o_ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
    o_lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
    o_ifu_rdata     = o_ifu_rsp_valid ? i_mem_rdata : '0;
    o_lsu_rdata     = o_lsu_rsp_valid ? i_mem_rdata : '0;
  end

endmodule
